// File: rtl/slave_port_v3.sv
// slave_port_v3: bit-serial bus slave with windowed register file, decode errors, input timeout and read latency
module slave_port_v3 #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 64,
  parameter int BASE_ADDR  = 'h0100,
  parameter int RD_LATENCY = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  input  logic master_ready,
  output logic rd_bus,
  output logic slave_ready,
  output logic slave_valid,
  output logic slave_err
);
  localparam int BW = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(RD_LATENCY + 1);
  localparam int XW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LO = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] HI = (ADDR_WIDTH+1)'(BASE_ADDR + MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RD_WAIT, SEND, ERR} state_t;

  state_t                state, state_nx;
  logic [BW-1:0]         bcnt;
  logic [TW-1:0]         icnt;
  logic [LW-1:0]         lcnt;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  mode_r, mode_now, last_a, last_d, to;
  logic [XW-1:0]         idx;

  // Window test done one bit wider so BASE_ADDR+MEM_DEPTH never wraps
  function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} >= LO && {1'b0, a} < HI;
  endfunction

  assign addr_nx     = {addr[ADDR_WIDTH-2:0], wr_bus};
  assign idx         = XW'(addr - ADDR_WIDTH'(BASE_ADDR));
  assign last_a      = bcnt == BW'(ADDR_WIDTH - 1);
  assign last_d      = bcnt == BW'(DATA_WIDTH - 1);
  assign to          = icnt == TW'(TIMEOUT - 1);
  assign mode_now    = bcnt == '0 ? mode : mode_r;
  assign slave_ready = state == ADDR || state == DATA;
  assign slave_valid = state == SEND;
  assign slave_err   = state == ERR;
  assign rd_bus      = slave_valid & shreg[DATA_WIDTH-1];

  // State register
  always_ff @(posedge clk)
    state <= !rstn ? IDLE : state_nx;

  // Next-state decode: phase completion, decode outcome, timeout, read latency, send completion
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = master_valid ? ADDR : IDLE;
      ADDR:    state_nx = !master_valid ? (to ? ERR : ADDR) :
                          !last_a ? ADDR : mode_now ? DATA : in_rng(addr_nx) ? RD_WAIT : ERR;
      DATA:    state_nx = !master_valid ? (to ? ERR : DATA) :
                          !last_d ? DATA : in_rng(addr) ? WRITE : ERR;
      WRITE:   state_nx = IDLE;
      RD_WAIT: state_nx = lcnt == LW'(RD_LATENCY - 1) ? SEND : RD_WAIT;
      SEND:    state_nx = master_ready && last_d ? IDLE : SEND;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift registers and counters; out-of-range writes still shift data to keep the stream aligned
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bcnt   <= '0;
      icnt   <= '0;
      lcnt   <= '0;
      addr   <= '0;
      shreg  <= '0;
      mode_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bcnt <= '0;
          icnt <= '0;
          lcnt <= '0;
        end
        ADDR, DATA: begin
          if (master_valid) begin
            icnt <= '0;
            bcnt <= (state == ADDR ? last_a : last_d) ? '0 : bcnt + 1'b1;
            if (state == ADDR) addr <= addr_nx;
            if (state == ADDR && bcnt == '0) mode_r <= mode;
            if (state == DATA) shreg <= {shreg[DATA_WIDTH-2:0], wr_bus};
          end else begin
            icnt <= icnt == TW'(TIMEOUT) ? icnt : icnt + 1'b1;
          end
        end
        RD_WAIT: begin
          shreg <= mem[idx];
          lcnt  <= lcnt + 1'b1;
        end
        SEND: begin
          if (master_ready) begin
            shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            bcnt  <= last_d ? '0 : bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file write; reset suppresses the write
  always_ff @(posedge clk)
    if (rstn && state == WRITE) mem[idx] <= shreg;
endmodule

// File: tb/tb_slave_port_v3.sv
// tb_slave_port_v3: randomized self-checking bench for slave_port_v3 against a memory-array model
module tb_slave_port_v3;
  localparam int BASE = 'h0100;
  localparam int DEPTH = 64;
  localparam int LAT = 2;

  logic clk = 0, rstn = 0, mode = 0, wr_bus = 0, master_valid = 0, master_ready = 0;
  logic rd_bus, slave_ready, slave_valid, slave_err;
  int vectors = 0, miscompares = 0;
  logic [7:0] mem_m [DEPTH];

  slave_port_v3 #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE),
                  .RD_LATENCY(LAT), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid),
    .master_ready(master_ready), .rd_bus(rd_bus), .slave_ready(slave_ready),
    .slave_valid(slave_valid), .slave_err(slave_err));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic bit in_win(input logic [15:0] a);
    return int'(a) >= BASE && int'(a) < BASE + DEPTH;
  endfunction

  function automatic logic [15:0] rnd_addr();
    return 16'(BASE + $urandom_range(0, DEPTH - 1));
  endfunction

  task automatic push_bit(input logic b);
    int n = 0;
    wr_bus = b;
    master_valid = 1'b1;
    while (!slave_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!slave_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_ready got slave_ready=%b want 1", slave_ready);
    end
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] v, input int nb, input int gap_at, input int gap_len);
    for (int i = nb - 1; i >= 0; i--) begin
      if (nb - 1 - i == gap_at && gap_len > 0) begin
        master_valid = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      push_bit(v[i]);
    end
  endtask

  task automatic check_idle(input string tag);
    vectors++;
    if (slave_err !== 1'b0 || slave_valid !== 1'b0 || slave_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle got err=%b valid=%b ready=%b want 0 0 0", tag, slave_err, slave_valid, slave_ready);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int gap_at, input int gap_len);
    bit e;
    e = !in_win(a);
    mode = 1'b1;
    push_word(a, 16, gap_at, gap_len);
    push_word({8'h00, d}, 8, -1, 0);
    master_valid = 1'b0;
    vectors++;
    if (slave_err !== e) begin
      miscompares++;
      $display("FAIL wr_err addr=%h got %b want %b", a, slave_err, e);
    end
    if (!e) mem_m[int'(a) - BASE] = d;
    @(negedge clk);
    check_idle("wr");
  endtask

  task automatic recv_read(input logic [15:0] a, input int duty);
    logic [7:0] exp;
    int k = 0, cyc = 0;
    exp = mem_m[int'(a) - BASE];
    for (int i = 0; i < LAT; i++) begin
      vectors++;
      if (slave_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_latency addr=%h cycle %0d got valid=%b want 0", a, i, slave_valid);
      end
      @(negedge clk);
    end
    while (k < 8 && cyc < 64) begin
      master_ready = (cyc % duty) == duty - 1;
      vectors++;
      if (slave_valid !== 1'b1 || rd_bus !== exp[7-k]) begin
        miscompares++;
        $display("FAIL rd_bit%0d addr=%h got valid=%b bit=%b want valid=1 bit=%b", k, a, slave_valid, rd_bus, exp[7-k]);
      end
      @(negedge clk);
      if (master_ready) k++;
      cyc++;
    end
    master_ready = 1'b0;
    check_idle("rd_end");
  endtask

  task automatic do_read(input logic [15:0] a, input int duty);
    mode = 1'b0;
    push_word(a, 16, -1, 0);
    master_valid = 1'b0;
    if (in_win(a)) recv_read(a, duty);
    else begin
      vectors++;
      if (slave_err !== 1'b1 || slave_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_decode addr=%h got err=%b valid=%b want 1 0", a, slave_err, slave_valid);
      end
      @(negedge clk);
      check_idle("rd_decode");
      @(negedge clk);
      check_idle("rd_decode2");
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    master_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rd_bus, slave_ready, slave_valid, slave_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 0000", {rd_bus, slave_ready, slave_valid, slave_err});
    end
    master_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) do_write(16'(BASE + i), 8'($urandom), -1, 0);
  endtask

  task automatic test_basic();
    do_write(16'h0105, 8'hA5, -1, 0);
    do_read(16'h0105, 1);
  endtask

  task automatic test_stall();
    logic [15:0] a;
    a = 16'h0117;
    do_write(a, 8'h5E, 6, 3);
    do_read(a, 1);
    mode = 1'b1;
    for (int i = 15; i >= 8; i--) push_bit(a[i]);
    master_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      vectors++;
      if (slave_err !== (i == 4)) begin
        miscompares++;
        $display("FAIL timeout_err cycle %0d got %b want %b", i, slave_err, i == 4);
      end
    end
    check_idle("timeout");
    do_read(a, 1);
  endtask

  task automatic test_decode();
    do_read(16'h0200, 1);
    do_write(16'h00FF, 8'h3C, -1, 0);
    do_write(16'h0140, 8'h77, -1, 0);
    do_read(16'h00FF, 1);
    do_read(16'h013F, 1);
    do_read(16'h0100, 1);
  endtask

  task automatic test_duty();
    do_read(16'h0105, 3);
    do_read(rnd_addr(), 2);
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    logic [7:0] d;
    a = rnd_addr();
    d = ~mem_m[int'(a) - BASE];
    mode = 1'b1;
    push_word(a, 16, -1, 0);
    for (int i = 7; i >= 4; i--) push_bit(d[i]);
    wr_bus = d[3];
    master_valid = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rd_bus, slave_ready, slave_valid, slave_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_outputs got %b want 0000", {rd_bus, slave_ready, slave_valid, slave_err});
    end
    master_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    do_read(a, 1);
    do_write(a, d, -1, 0);
    do_read(a, 1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [7:0] d;
    a = rnd_addr();
    d = 8'($urandom);
    mode = 1'b1;
    push_word(a, 16, -1, 0);
    push_word({8'h00, d}, 8, -1, 0);
    mem_m[int'(a) - BASE] = d;
    mode = 1'b0;
    push_word(a, 16, -1, 0);
    master_valid = 1'b0;
    recv_read(a, 1);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int t = 0; t < 40; t++) begin
      a = $urandom_range(0, 3) == 0 ? 16'($urandom) : rnd_addr();
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), $urandom_range(1, 15), $urandom_range(0, 3));
      else do_read(a, $urandom_range(1, 3));
    end
  endtask

  task automatic test_readall();
    for (int i = 0; i < DEPTH; i++) do_read(16'(BASE + i), 1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_basic();
    test_stall();
    test_decode();
    test_duty();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_readall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
